csr_trap_unit: RTL
==================

// Module: csr_trap_unit
// PURPOSE
//  Commit-side consumer of the per-instruction csr_data_t bundle: owns the M-mode CSR file, applies CSR writes at commit,
//  and turns exceptions, interrupts and MRET into a pipeline flush plus a PC redirect. Sits after the memory stage,
//  beside the writeback stage. Provides the combinational CSR read port used by decode.
// PARAMETERS
//  MTVEC_RESET  64'h0  reset value of mtvec
//  MHARTID      64'h0  value returned by mhartid (0xF14)
//  VECTOR_EN    1      1: honour mtvec.MODE=1 (vectored interrupts); 0: always direct
// PORTS
//  clk           in   1    clock
//  reset         in   1    asynchronous, active-low reset
//  commit_valid  in   1    instruction retires this cycle (memory-stage en)
//  commit_pc     in   64   pc of retiring instruction
//  csr_data      in   csr_data_t  wa/ra/wd/alufunc_csr/wvalid/is_mret/is_ecall/is_exception/exception of retiring instr
//  mem_addr      in   64   data address of retiring instr (mtval for load/store misaligned)
//  irq_sw/irq_timer/irq_ext  in  1 each  level interrupt lines, mirrored into mip.MSIP/MTIP/MEIP
//  csr_ra        in   12   decode-stage CSR read address
//  csr_rd        out  64   CSR value at csr_ra (combinational, pre-write value)
//  flush         out  1    kill all younger instructions (combinational, cycle of trap/mret commit)
//  busy          out  1    unit handling trap/mret; upstream must not present commit_valid
//  redirect_valid out 1    one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc   out  64   target pc
//  priv          out  2    current privilege (2'b11 M, 2'b00 U)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; priv=M; mstatus, mie, mscratch, mepc, mcause, mtval, mcycle = 0;
//   mtvec=MTVEC_RESET; redirect_valid=0, redirect_pc=0, busy=0. Reset mid-trap abandons the trap, no redirect.
//  CSRs: mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11; other bits read 0), mie 0x304 (b3/7/11 only), mtvec 0x305,
//   mscratch 0x340, mepc 0x341 (b1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only), mcycle 0xB00,
//   mhartid 0xF14 (read-only). Unknown address: read 0, write ignored.
//  mcycle +1 every cycle; a CSR write to mcycle in the same cycle wins (no increment).
//  CSR write at commit (commit_valid & wvalid & no trap taken): ALU_ASSIGN new=wd; ALU_OR new=old|wd;
//   ALU_AND_NOT new=old&~wd. Written on the clock edge ending the commit cycle.
//  Trap decision, cycle N with commit_valid & state==IDLE:
//   int_en = (priv!=M) | mstatus.MIE; pend = mip & mie; priority MEIP > MSIP > MTIP.
//   1) int_en & pend!=0 -> interrupt; instruction is NOT retired (its CSR write dropped), mepc=commit_pc,
//      mcause = 0x8000_0000_0000_000b / _0003 / _0007, mtval=0.
//   2) else is_exception -> mcause per exception code (inst-misaligned 0, illegal 2, load-mis 4, store-mis 6,
//      ecall-U 8, ecall-M 0xb); mtval = commit_pc (inst-mis), mem_addr (load/store-mis), else 0; mepc=commit_pc.
//   3) else is_mret -> mret.
//  Trap entry (edge ending N): MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M, state<=TRAP.
//  MRET (edge ending N): priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=U, state<=RET.
//  flush=1 combinationally in cycle N for cases 1-3.
//  Cycle N+1 (TRAP/RET): busy=1, redirect_valid=1 (registered, exactly one cycle);
//   TRAP: redirect_pc = {mtvec[63:2],2'b00}, plus 4*cause[3:0] if VECTOR_EN & mtvec[1:0]==1 & interrupt;
//   RET: redirect_pc = mepc. State returns to IDLE at end of N+1; busy=0 from N+2.
//  commit_valid while busy: ignored entirely (protocol error; bench asserts it never happens).
//  mip bits follow irq_* with one register stage; pend uses the registered mip.
// TESTING
//  ecall in U (priv=U, mtvec=0x8000_0100, commit_pc=0x8000_0040) -> flush@N; @N+1 redirect 0x8000_0100,
//   mepc=0x8000_0040, mcause=8, MPP=00, priv=M.
//  csrrs mscratch wd=0xF0 then csrrc wd=0x30 from 0x0F -> mscratch=0xFF then 0xCF; no flush, no redirect.
//  mie.MTIP=1, MIE=1, irq_timer=1, commit of csrrw mtval -> interrupt wins, mtval write dropped,
//   mcause=0x8000_0000_0000_0007, mepc=commit_pc.
//  Vectored: mtvec=0x8000_0001, irq_ext -> redirect 0x8000_002C; same with exception -> redirect 0x8000_0000.
//  mret with mepc=0x8000_1234, MPIE=1, MPP=00 -> redirect 0x8000_1234, priv=U, MIE=1, MPP=00.
//  reset asserted in TRAP cycle -> redirect_valid=0 immediately, priv=M, mtvec=MTVEC_RESET.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Commit-side M-mode CSR file plus trap/MRET sequencer: applies CSR writes at retirement and
// converts interrupts, exceptions and MRET into a flush and a one-cycle fetch redirect.
package csr_trap_pkg;
   typedef enum logic [1:0] {
      ALU_ASSIGN  = 2'd0,
      ALU_OR      = 2'd1,
      ALU_AND_NOT = 2'd2
   } alufunc_csr_t;

   typedef enum logic [2:0] {
      EXC_NONE      = 3'd0,
      EXC_INST_MIS  = 3'd1,
      EXC_ILLEGAL   = 3'd2,
      EXC_LOAD_MIS  = 3'd3,
      EXC_STORE_MIS = 3'd4
   } exception_t;

   typedef struct packed {
      logic [11:0]  wa;
      logic [11:0]  ra;
      logic [63:0]  wd;
      alufunc_csr_t alufunc_csr;
      logic         wvalid;
      logic         is_mret;
      logic         is_ecall;
      logic         is_exception;
      exception_t   exception;
   } csr_data_t;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_U = 2'b00;
endpackage

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting commits; trap/mret decision made combinationally
// TRAP  | trap entered on previous edge; redirect to mtvec target, busy
// RET   | mret taken on previous edge; redirect to mepc, busy
module csr_trap_unit
   import csr_trap_pkg::*;
#(
   parameter logic [63:0] MTVEC_RESET = 64'h0,
   parameter logic [63:0] MHARTID     = 64'h0,
   parameter bit          VECTOR_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit_valid,
   input  logic [63:0] commit_pc,
   input  csr_data_t   csr_data,
   input  logic [63:0] mem_addr,
   input  logic        irq_sw,
   input  logic        irq_timer,
   input  logic        irq_ext,
   input  logic [11:0] csr_ra,
   output logic [63:0] csr_rd,
   output logic        flush,
   output logic        busy,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic [1:0]  priv
);

   typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

   localparam logic [63:0] MIE_MASK = 64'h0000_0000_0000_0888;

   state_t      state_q, state_d;
   logic [1:0]  priv_q;
   logic        mstatus_mie, mstatus_mpie;
   logic [1:0]  mstatus_mpp;
   logic [63:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q, mcycle_q;
   logic [63:0] mstatus_rd, mip_d;
   logic        redirect_valid_q;
   logic [63:0] redirect_pc_q;

   logic        take, int_en, take_int, take_exc, take_mret, take_trap, do_write;
   logic [63:0] pend;
   logic [3:0]  int_code, exc_code;
   logic [63:0] trap_cause, trap_tval, trap_target, redirect_pc_d;
   logic [63:0] w_old, w_new;
   logic        unused_ra;

   assign unused_ra = ^csr_data.ra;

   assign mstatus_rd = {51'b0, mstatus_mpp, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign mip_d      = {52'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

   function automatic logic [63:0] csr_read(input logic [11:0] a);
      logic [63:0] v;
      v = 64'h0;
      case (a)
         CSR_MSTATUS:  v = mstatus_rd;
         CSR_MIE:      v = mie_q;
         CSR_MTVEC:    v = mtvec_q;
         CSR_MSCRATCH: v = mscratch_q;
         CSR_MEPC:     v = mepc_q;
         CSR_MCAUSE:   v = mcause_q;
         CSR_MTVAL:    v = mtval_q;
         CSR_MIP:      v = mip_q;
         CSR_MCYCLE:   v = mcycle_q;
         CSR_MHARTID:  v = MHARTID;
         default:      v = 64'h0;
      endcase
      return v;
   endfunction

   assign csr_rd = csr_read(csr_ra);

   // Trap decision for the retiring instruction
   always_comb begin
      take      = commit_valid & (state_q == S_IDLE);
      int_en    = (priv_q != PRIV_M) | mstatus_mie;
      pend      = mip_q & mie_q;
      take_int  = take & int_en & (|pend);
      take_exc  = take & ~take_int & (csr_data.is_exception | csr_data.is_ecall);
      take_mret = take & ~take_int & ~take_exc & csr_data.is_mret;
      take_trap = take_int | take_exc;
      do_write  = take & csr_data.wvalid & ~take_trap & ~take_mret;
      flush     = take_trap | take_mret;

      int_code = 4'd7;
      if (pend[11])     int_code = 4'd11;
      else if (pend[3]) int_code = 4'd3;

      exc_code  = 4'd2;
      trap_tval = 64'h0;
      if (csr_data.is_ecall) begin
         exc_code = (priv_q == PRIV_U) ? 4'd8 : 4'd11;
      end else begin
         case (csr_data.exception)
            EXC_INST_MIS: begin
               exc_code  = 4'd0;
               trap_tval = commit_pc;
            end
            EXC_LOAD_MIS: begin
               exc_code  = 4'd4;
               trap_tval = mem_addr;
            end
            EXC_STORE_MIS: begin
               exc_code  = 4'd6;
               trap_tval = mem_addr;
            end
            default: exc_code = 4'd2;
         endcase
      end

      if (take_int) begin
         trap_cause = {1'b1, 59'b0, int_code};
         trap_tval  = 64'h0;
      end else begin
         trap_cause = {60'b0, exc_code};
      end

      trap_target = {mtvec_q[63:2], 2'b00};
      if (VECTOR_EN && (mtvec_q[1:0] == 2'b01) && take_int)
         trap_target = trap_target + {58'b0, int_code, 2'b00};

      redirect_pc_d = take_mret ? mepc_q : trap_target;
   end

   always_comb begin
      w_old = csr_read(csr_data.wa);
      case (csr_data.alufunc_csr)
         ALU_OR:      w_new = w_old | csr_data.wd;
         ALU_AND_NOT: w_new = w_old & ~csr_data.wd;
         default:     w_new = csr_data.wd;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (take_trap)      state_d = S_TRAP;
            else if (take_mret) state_d = S_RET;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         priv_q           <= PRIV_M;
         mstatus_mie      <= 1'b0;
         mstatus_mpie     <= 1'b0;
         mstatus_mpp      <= PRIV_U;
         mie_q            <= 64'h0;
         mtvec_q          <= MTVEC_RESET;
         mscratch_q       <= 64'h0;
         mepc_q           <= 64'h0;
         mcause_q         <= 64'h0;
         mtval_q          <= 64'h0;
         mip_q            <= 64'h0;
         mcycle_q         <= 64'h0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 64'h0;
      end else begin
         mip_q            <= mip_d;
         mcycle_q         <= mcycle_q + 64'd1;
         redirect_valid_q <= take_trap | take_mret;
         if (take_trap | take_mret) redirect_pc_q <= redirect_pc_d;

         if (take_trap) begin
            mepc_q       <= {commit_pc[63:2], 2'b00};
            mcause_q     <= trap_cause;
            mtval_q      <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mstatus_mpp  <= priv_q;
            priv_q       <= PRIV_M;
         end else if (take_mret) begin
            priv_q       <= mstatus_mpp;
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            mstatus_mpp  <= PRIV_U;
         end else if (do_write) begin
            // Only M and U exist, so any MPP other than 11 collapses to U
            case (csr_data.wa)
               CSR_MSTATUS: begin
                  mstatus_mie  <= w_new[3];
                  mstatus_mpie <= w_new[7];
                  mstatus_mpp  <= (w_new[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
               end
               CSR_MIE:      mie_q      <= w_new & MIE_MASK;
               CSR_MTVEC:    mtvec_q    <= w_new;
               CSR_MSCRATCH: mscratch_q <= w_new;
               CSR_MEPC:     mepc_q     <= {w_new[63:2], 2'b00};
               CSR_MCAUSE:   mcause_q   <= w_new;
               CSR_MTVAL:    mtval_q    <= w_new;
               CSR_MCYCLE:   mcycle_q   <= w_new;
               default: ;
            endcase
         end
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign priv           = priv_q;

endmodule
